omsp_uspi_slave: RTL
====================

Name: omsp_uspi_slave

Overview:
- SPI slave (responder) peripheral for the OpenMSP430 peripheral bus; the counterpart of the existing master-only SPI controller.
- Samples an externally driven spi_clk, spi_mosi and spi_cs_n, all oversampled in the mclk domain.
- Double-buffered TX and RX data registers, selectable CPOL/CPHA, 8- or 16-bit words.
- Level interrupt to the CPU on data events and errors.

Parameters:
- BASE_ADDR, 15'h0098: register block base byte address, aligned to 2^DEC_WD.
- DEC_WD, 3: decoder width. Offsets are CTRL=0, STAT=2, TXDATA=4, RXDATA=6.

Ports:
- mclk, in, 1: main system clock.
- puc_rst_n, in, 1: asynchronous, active-low reset.
- per_addr, in, 14: peripheral word address.
- per_din, in, 16: peripheral write data.
- per_en, in, 1: peripheral enable.
- per_we, in, 2: byte write enables.
- per_dout, out, 16: read data. Zero when the block is not selected.
- spi_clk, in, 1: SPI clock from the master, asynchronous to mclk.
- spi_mosi, in, 1: master out, slave in.
- spi_cs_n, in, 1: active-low chip select.
- spi_miso, out, 1: slave out, master in.
- spi_miso_oe, out, 1: pad output enable for spi_miso.
- spi_irq, out, 1: level interrupt.

Behaviour:
- Decode:
  - reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]).
  - A write is any per_we bit set; a read is per_we == 0.
  - per_dout is combinational from the selected register.
- CTRL register (read/write, reset 0):
  - [0] EN
  - [1] CPOL: idle clock level.
  - [2] CPHA: 0 = sample on leading edge, 1 = sample on trailing edge.
  - [3] RXIE, [4] TXIE, [5] ERRIE
  - [8] WIDE: 1 = 16-bit words, 0 = 8-bit words using bits [7:0].
  - All other bits read as 0.
- STAT register:
  - [0] RXFULL (read-only)
  - [1] TXEMPTY (read-only, reset 1)
  - [2] OVR, [3] UNDR, [4] ABORT: write 1 to clear.
  - [5] BUSY (read-only): synchronized chip select is active.
  - Reset value 16'h0002.
- TXDATA: write loads the TX buffer and clears TXEMPTY. Reads return the buffer.
- RXDATA: read returns the RX buffer and clears RXFULL on that cycle. Writes are ignored.
- Input synchronization:
  - spi_clk, spi_mosi and spi_cs_n each pass through two flops, reset to 1, 0 and 1.
  - Clock edges are detected from the 3rd stage against the 2nd stage.
  - A bus edge is visible 2-3 mclk after the pad edge.
  - Supported spi_clk is at most mclk/4 when EN=1.
- Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- Frame state machine (IDLE, ACTIVE). While EN=0 it is held in IDLE.
  - IDLE -> ACTIVE on synchronized cs_n falling:
    - bit_cnt = WIDE ? 15 : 7.
    - Shift register loads from the TX buffer. If TXEMPTY=1, load 0 and set UNDR.
    - TXEMPTY is set.
  - Any state -> IDLE on cs_n rising. If bit_cnt is not at its start value (partial word), set ABORT and discard the partial RX bits.
- Shifting, MSB first:
  - Sample edge: rx_shift = {rx_shift, mosi_sync}.
  - Shift edge: tx_shift <<= 1.
  - With CPHA=0 the first bit is valid on spi_miso from the load, before the first edge.
  - With CPHA=1 the first shift edge presents the first bit and no shift occurs before it.
- Word completion is on the sample edge where bit_cnt = 0:
  - The RX buffer takes the assembled word, zero-extended in 8-bit mode.
  - If RXFULL was already 1, set OVR; the buffer is still overwritten.
  - RXFULL is set.
  - bit_cnt reloads and the TX buffer reloads per the IDLE->ACTIVE load rule, enabling back-to-back words.
- spi_miso = tx_shift[WIDE ? 15 : 7].
- spi_miso_oe = EN & state==ACTIVE.
- spi_irq = (RXIE & RXFULL) | (TXIE & TXEMPTY) | (ERRIE & (OVR | UNDR | ABORT)).
- Simultaneous events:
  - RXDATA read in the same cycle as word completion: the new word is stored, RXFULL stays 1, no OVR.
  - TXDATA write in the same cycle as a load with TXEMPTY=1: the written value goes directly to the shift register, TXEMPTY stays 1, no UNDR.
  - W1C write in the same cycle as a flag set: the set wins.
- Clearing EN mid-frame:
  - Immediately returns to IDLE and drives spi_miso_oe to 0.
  - No ABORT is set.
  - Buffers and flags are retained.
- Reset, including mid-frame: all registers go to reset values, spi_miso=0, spi_miso_oe=0, spi_irq=0, per_dout=0.

Test Plan:
- Reset, then read STAT and CTRL -> 16'h0002 and 16'h0000; spi_miso_oe=0, spi_irq=0.
- 8-bit word:
  - Stimulus: EN, CPOL=0, CPHA=0, RXIE set; TXDATA=8'hA5; master sends 8'h3C at mclk/8.
  - Response: MISO carries A5 MSB first; RXDATA=16'h003C; spi_irq high until RXDATA is read.
- 16-bit word, all four CPOL/CPHA modes: TX 16'hBEEF, master sends 16'h1234 -> RX 16'h1234 and master receives BEEF in every mode.
- Back-to-back words, TX buffer refilled once:
  - Stimulus: master clocks two 8-bit words 8'h11, 8'h22 without reading RXDATA.
  - Response: 2nd word reads 0x00 with UNDR=1; OVR=1; RXDATA=8'h22.
- Abort: cs_n rises after 3 bits -> ABORT=1, RXFULL unchanged. Writing STAT=16'h0010 clears ABORT.
- Coincidence: RXDATA read in the completion cycle -> no OVR and RXFULL=1. puc_rst_n asserted mid-word -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/omsp_uspi_slave.sv
// rtl/omsp_uspi_slave.sv - SPI slave peripheral for the OpenMSP430 peripheral bus
// Double-buffered TX/RX, CPOL/CPHA select, 8/16-bit words, level interrupt.
module omsp_uspi_slave #(
    parameter logic [14:0] BASE_ADDR = 15'h0098,
    parameter int          DEC_WD    = 3
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        spi_irq
);

    localparam int IDX_W = DEC_WD - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state;
    logic        en, cpol, cpha, rxie, txie, errie, wide;
    logic        rxfull, txempty, ovr, undr, abort;
    logic [15:0] tx_buf, rx_buf, tx_shift;
    logic [14:0] rx_shift;
    logic [3:0]  bit_cnt;
    logic        skip_shift;

    logic [2:0]  clk_sync, cs_sync;
    logic [1:0]  mosi_sync;

    // Register decode
    logic [IDX_W-1:0] reg_idx;
    logic             reg_sel, reg_wr, reg_rd;
    logic             ctrl_wr, stat_wr, tx_wr, rx_rd;
    logic [15:0]      tx_wdata;
    logic [2:0]       stat_w1c;

    assign reg_idx  = per_addr[IDX_W-1:0];
    assign reg_sel  = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_wr   = reg_sel & (|per_we);
    assign reg_rd   = reg_sel & ~(|per_we);
    assign ctrl_wr  = reg_wr & (reg_idx == IDX_W'(0));
    assign stat_wr  = reg_wr & (reg_idx == IDX_W'(1));
    assign tx_wr    = reg_wr & (reg_idx == IDX_W'(2));
    assign rx_rd    = reg_rd & (reg_idx == IDX_W'(3));
    assign tx_wdata = {per_we[1] ? per_din[15:8] : tx_buf[15:8],
                       per_we[0] ? per_din[7:0]  : tx_buf[7:0]};
    assign stat_w1c = (stat_wr & per_we[0]) ? per_din[4:2] : 3'b000;

    // Pad synchronizers; the third stage only exists for edge detection
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            clk_sync  <= 3'b111;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[1:0], spi_clk};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    logic clk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, busy;

    assign clk_edge    = clk_sync[1] ^ clk_sync[2];
    assign lead_edge   = clk_edge & (clk_sync[1] != cpol);
    assign trail_edge  = clk_edge & (clk_sync[1] == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_sync[1] & cs_sync[2];
    assign cs_rise     = cs_sync[1] & ~cs_sync[2];
    assign busy        = ~cs_sync[1];

    // Frame events and the shared TX load rule
    logic [3:0]  start_cnt;
    logic        active, frame_start, word_done, load;
    logic        load_direct, undr_set, ovr_set, abort_set;
    logic [15:0] load_val, rx_word;

    assign start_cnt   = wide ? 4'd15 : 4'd7;
    assign active      = (state == ACTIVE);
    assign frame_start = en & ~active & cs_fall;
    assign word_done   = en & active & ~cs_rise & sample_edge & (bit_cnt == 4'd0);
    assign load        = frame_start | word_done;
    assign load_direct = load & txempty & tx_wr;
    assign undr_set    = load & txempty & ~tx_wr;
    assign load_val    = txempty ? (tx_wr ? tx_wdata : 16'h0000) : tx_buf;
    assign ovr_set     = word_done & rxfull & ~rx_rd;
    assign abort_set   = en & active & cs_rise & (bit_cnt != start_cnt);
    assign rx_word     = {rx_shift, mosi_sync[1]};

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= IDLE;
            en         <= 1'b0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            rxie       <= 1'b0;
            txie       <= 1'b0;
            errie      <= 1'b0;
            wide       <= 1'b0;
            rxfull     <= 1'b0;
            txempty    <= 1'b1;
            ovr        <= 1'b0;
            undr       <= 1'b0;
            abort      <= 1'b0;
            tx_buf     <= 16'h0000;
            rx_buf     <= 16'h0000;
            tx_shift   <= 16'h0000;
            rx_shift   <= 15'h0000;
            bit_cnt    <= 4'd0;
            skip_shift <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                if (per_we[0]) begin
                    en    <= per_din[0];
                    cpol  <= per_din[1];
                    cpha  <= per_din[2];
                    rxie  <= per_din[3];
                    txie  <= per_din[4];
                    errie <= per_din[5];
                end
                if (per_we[1]) begin
                    wide <= per_din[8];
                end
            end

            if (tx_wr) begin
                tx_buf <= tx_wdata;
            end
            if (tx_wr && !load_direct) begin
                txempty <= 1'b0;
            end else if (load) begin
                txempty <= 1'b1;
            end

            if (word_done) begin
                rx_buf <= wide ? rx_word : {8'h00, rx_word[7:0]};
                rxfull <= 1'b1;
            end else if (rx_rd) begin
                rxfull <= 1'b0;
            end

            ovr   <= ovr_set   | (ovr   & ~stat_w1c[0]);
            undr  <= undr_set  | (undr  & ~stat_w1c[1]);
            abort <= abort_set | (abort & ~stat_w1c[2]);

            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state      <= ACTIVE;
                            bit_cnt    <= start_cnt;
                            tx_shift   <= load_val;
                            // In CPHA=1 the first leading edge presents the MSB already loaded
                            skip_shift <= cpha;
                        end
                    end
                    ACTIVE: begin
                        if (cs_rise) begin
                            state    <= IDLE;
                            rx_shift <= 15'h0000;
                        end else begin
                            if (sample_edge) begin
                                rx_shift <= {rx_shift[13:0], mosi_sync[1]};
                                if (bit_cnt == 4'd0) begin
                                    bit_cnt    <= start_cnt;
                                    tx_shift   <= load_val;
                                    // The next shift edge would push out the fresh MSB
                                    skip_shift <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt - 4'd1;
                                end
                            end
                            if (shift_edge) begin
                                if (skip_shift) begin
                                    skip_shift <= 1'b0;
                                end else begin
                                    tx_shift <= {tx_shift[14:0], 1'b0};
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        if (reg_sel) begin
            case (reg_idx)
                IDX_W'(0): per_dout = {7'b0, wide, 2'b0, errie, txie, rxie, cpha, cpol, en};
                IDX_W'(1): per_dout = {10'b0, busy, abort, undr, ovr, txempty, rxfull};
                IDX_W'(2): per_dout = tx_buf;
                IDX_W'(3): per_dout = rx_buf;
                default:   per_dout = 16'h0000;
            endcase
        end
    end

    assign spi_miso    = wide ? tx_shift[15] : tx_shift[7];
    assign spi_miso_oe = en & active;
    assign spi_irq     = (rxie & rxfull) | (txie & txempty) | (errie & (ovr | undr | abort));

endmodule
